// File: rtl/ps2_keyboard_if.sv
// Keystroke handshake between the keyboard front end and the rotor pipeline.
// The master side holds a letter index; the slave side accepts it with key_ready.
interface ps2_keyboard_if;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: conditions the pins, receives 11-bit frames and turns
// letter make codes into one 5-bit index per physical key press.
module ps2_keyboard #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_ps2_clk,
    input  logic           i_ps2_data,
    ps2_keyboard_if.master kbd,
    output logic           o_frame_err,
    output logic           o_overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Set-2 make code to {hit, letter index}
    function automatic logic [5:0] letter_lookup(input logic [7:0] code);
        case (code)
            8'h1C:   letter_lookup = {1'b1, 5'd0};
            8'h32:   letter_lookup = {1'b1, 5'd1};
            8'h21:   letter_lookup = {1'b1, 5'd2};
            8'h23:   letter_lookup = {1'b1, 5'd3};
            8'h24:   letter_lookup = {1'b1, 5'd4};
            8'h2B:   letter_lookup = {1'b1, 5'd5};
            8'h34:   letter_lookup = {1'b1, 5'd6};
            8'h33:   letter_lookup = {1'b1, 5'd7};
            8'h43:   letter_lookup = {1'b1, 5'd8};
            8'h3B:   letter_lookup = {1'b1, 5'd9};
            8'h42:   letter_lookup = {1'b1, 5'd10};
            8'h4B:   letter_lookup = {1'b1, 5'd11};
            8'h3A:   letter_lookup = {1'b1, 5'd12};
            8'h31:   letter_lookup = {1'b1, 5'd13};
            8'h44:   letter_lookup = {1'b1, 5'd14};
            8'h4D:   letter_lookup = {1'b1, 5'd15};
            8'h15:   letter_lookup = {1'b1, 5'd16};
            8'h2D:   letter_lookup = {1'b1, 5'd17};
            8'h1B:   letter_lookup = {1'b1, 5'd18};
            8'h2C:   letter_lookup = {1'b1, 5'd19};
            8'h3C:   letter_lookup = {1'b1, 5'd20};
            8'h2A:   letter_lookup = {1'b1, 5'd21};
            8'h1D:   letter_lookup = {1'b1, 5'd22};
            8'h22:   letter_lookup = {1'b1, 5'd23};
            8'h35:   letter_lookup = {1'b1, 5'd24};
            8'h1A:   letter_lookup = {1'b1, 5'd25};
            default: letter_lookup = {1'b0, 5'd0};
        endcase
    endfunction

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_filt_sr;
    logic                  r_clk_filt;

    logic [1:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_parity;
    logic [TW-1:0]         r_to_cnt;
    logic                  r_frame_err;

    logic                  r_ext;
    logic                  r_brk;
    logic                  r_held_vld;
    logic [4:0]            r_held_code;

    logic [4:0]            r_key_code;
    logic                  r_key_valid;
    logic                  r_overrun;

    logic                  w_fall;
    logic                  w_bit;
    logic                  w_frame_ok;
    logic                  w_byte_good;
    logic [5:0]            w_lk;
    logic                  w_emit;
    logic                  w_ext_nx;
    logic                  w_brk_nx;
    logic                  w_held_clr;
    logic                  w_ready;

    assign w_bit       = r_data_sync[1];
    assign w_fall      = r_clk_filt & (r_filt_sr == {FILTER_LEN{1'b0}});
    assign w_frame_ok  = w_bit & (^{r_shift, r_parity});
    assign w_byte_good = w_fall & (r_state == S_STOP) & w_frame_ok;
    assign w_ready     = kbd.key_ready;

    // Pin synchronizers and ps2_clk glitch filter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt_sr   <= {FILTER_LEN{1'b1}};
            r_clk_filt  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_filt_sr   <= {r_filt_sr[FILTER_LEN-2:0], r_clk_sync[1]};
            if (r_filt_sr == {FILTER_LEN{1'b1}}) begin
                r_clk_filt <= 1'b1;
            end else if (r_filt_sr == {FILTER_LEN{1'b0}}) begin
                r_clk_filt <= 1'b0;
            end else begin
                r_clk_filt <= r_clk_filt;
            end
        end
    end

    // Frame receiver with mid-frame timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_parity    <= 1'b0;
            r_to_cnt    <= {TW{1'b0}};
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_state == S_IDLE) begin
                r_to_cnt <= {TW{1'b0}};
                if (w_fall && !w_bit) begin
                    r_state   <= S_DATA;
                    r_bit_cnt <= 3'd0;
                end
            end else if (w_fall) begin
                r_to_cnt <= {TW{1'b0}};
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= w_bit;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!w_frame_ok) begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_to_cnt == TO_LIMIT) begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
                r_to_cnt    <= {TW{1'b0}};
            end else begin
                r_to_cnt <= r_to_cnt + TO_ONE;
            end
        end
    end

    // Scan-code decoder: prefixes, break release and typematic suppression
    always_comb begin
        w_lk       = letter_lookup(r_shift);
        w_emit     = 1'b0;
        w_ext_nx   = r_ext;
        w_brk_nx   = r_brk;
        w_held_clr = 1'b0;
        if (w_byte_good) begin
            if (r_shift == 8'hE0) begin
                w_ext_nx = 1'b1;
            end else if (r_shift == 8'hF0) begin
                w_brk_nx = 1'b1;
            end else if (r_ext) begin
                w_ext_nx = 1'b0;
                w_brk_nx = 1'b0;
            end else if (r_brk) begin
                w_brk_nx   = 1'b0;
                w_held_clr = w_lk[5] & r_held_vld & (w_lk[4:0] == r_held_code);
            end else if (w_lk[5] && !(r_held_vld && (r_held_code == w_lk[4:0]))) begin
                w_emit = 1'b1;
            end else begin
                w_emit = 1'b0;
            end
        end else begin
            w_emit = 1'b0;
        end
    end

    // Decoder flags and held-key tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_held_vld  <= 1'b0;
            r_held_code <= 5'd0;
        end else begin
            r_ext <= w_ext_nx;
            r_brk <= w_brk_nx;
            if (w_emit) begin
                r_held_vld  <= 1'b1;
                r_held_code <= w_lk[4:0];
            end else if (w_held_clr) begin
                r_held_vld <= 1'b0;
            end
        end
    end

    // Single-entry output register; a full, stalled register drops the letter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_code  <= 5'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_emit) begin
                if (!r_key_valid || w_ready) begin
                    r_key_code  <= w_lk[4:0];
                    r_key_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_key_valid && w_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign kbd.key_code  = r_key_code;
    assign kbd.key_valid = r_key_valid;
    assign o_frame_err   = r_frame_err;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed plus randomized frames checked against a keystroke-level model of the
// PS/2 letter decoder.
module tb_ps2_keyboard;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic frame_err;
    logic overrun;

    ps2_keyboard_if kbd();

    ps2_keyboard #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .kbd         (kbd),
        .o_frame_err (frame_err),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // observed activity
    int got_q[$];
    int cnt_ferr = 0;
    int cnt_ovr  = 0;
    int cnt_vhi  = 0;
    int wide_pulses = 0;

    // model state
    byte unsigned letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    int exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int m_ext  = 0;
    int m_brk  = 0;
    int m_held = -1;
    int m_full = 0;
    int m_pend = 0;
    int m_ready = 1;

    initial begin : monitor
        logic prev_ferr;
        logic prev_ovr;
        prev_ferr = 1'b0;
        prev_ovr  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ferr = 1'b0;
                prev_ovr  = 1'b0;
            end else begin
                if (kbd.key_valid && kbd.key_ready) got_q.push_back(int'(kbd.key_code));
                if (kbd.key_valid) cnt_vhi++;
                if (frame_err) cnt_ferr++;
                if (overrun) cnt_ovr++;
                if ((frame_err && prev_ferr) || (overrun && prev_ovr)) wide_pulses++;
                prev_ferr = frame_err;
                prev_ovr  = overrun;
            end
        end
    end

    function automatic int lookup(byte unsigned b);
        for (int i = 0; i < 26; i++) if (letters[i] == b) return i;
        return -1;
    endfunction

    task automatic model_frame(byte unsigned b, bit par_bad, bit stop_bit);
        int l;
        if (par_bad || !stop_bit) begin
            exp_ferr++;
            return;
        end
        l = lookup(b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_ext != 0) begin m_ext = 0; m_brk = 0; end
        else if (m_brk != 0) begin
            m_brk = 0;
            if (l >= 0 && l == m_held) m_held = -1;
        end else if (l >= 0 && l != m_held) begin
            m_held = l;
            if (m_full == 0 && m_ready != 0) exp_q.push_back(l);
            else if (m_full == 0) begin m_full = 1; m_pend = l; end
            else exp_ovr++;
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bits(logic [10:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame_bits(byte unsigned b, bit par_bad, bit stop_bit);
        logic [7:0] d;
        d = b;
        return {stop_bit, (~^d) ^ par_bad, d, 1'b0};
    endfunction

    task automatic send(byte unsigned b, bit par_bad, bit stop_bit);
        ps2_bits(frame_bits(b, par_bad, stop_bit), 11);
        ps2_data = 1'b1;
        cyc(HALF + FL + 10);
        model_frame(b, par_bad, stop_bit);
    endtask

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ":xfers"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, ":code"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, ":frame_err"}, cnt_ferr, exp_ferr);
        chk({tag, ":overrun"}, cnt_ovr, exp_ovr);
        chk({tag, ":pulse_width"}, wide_pulses, 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int l;
        int r;
        byte unsigned b;
        byte unsigned prev;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        kbd.key_ready = 1'b1;
        cyc(5);
        chk("reset:key_valid", int'(kbd.key_valid), 0);
        chk("reset:key_code", int'(kbd.key_code), 0);
        chk("reset:frame_err", int'(frame_err), 0);
        chk("reset:overrun", int'(overrun), 0);
        rst = 1'b0;
        cyc(5);

        // single letter A
        send(8'h1C, 1'b0, 1'b1);
        compare_all("t1");
        chk("t1:valid_cycles", cnt_vhi, 1);

        // release A, then repeats / break / press
        send(8'hF0, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        compare_all("t2");

        // parity and stop errors
        send(8'h1C, 1'b1, 1'b1);
        send(8'h1A, 1'b0, 1'b0);
        compare_all("t3");

        // extended and non-letter codes, then Z
        send(8'hE0, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        send(8'h5A, 1'b0, 1'b1);
        send(8'h1A, 1'b0, 1'b1);
        compare_all("t4");

        // stalled consumer: second letter overruns
        kbd.key_ready = 1'b0;
        m_ready = 0;
        send(8'h32, 1'b0, 1'b1);
        send(8'h21, 1'b0, 1'b1);
        chk("t5:held_valid", int'(kbd.key_valid), 1);
        chk("t5:held_code", int'(kbd.key_code), m_pend);
        compare_all("t5a");
        kbd.key_ready = 1'b1;
        m_ready = 1;
        if (m_full != 0) exp_q.push_back(m_pend);
        m_full = 0;
        cyc(3);
        compare_all("t5b");
        chk("t5:valid_after", int'(kbd.key_valid), 0);

        // timeout after 5 bits, then D
        ps2_bits(frame_bits(8'h23, 1'b0, 1'b1), 5);
        ps2_data = 1'b1;
        cyc(TO + 50);
        exp_ferr++;
        compare_all("t6a");
        send(8'h23, 1'b0, 1'b1);
        compare_all("t6b");

        // randomized keystroke stream
        prev = 8'h1C;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) b = letters[$urandom_range(0, 25)];
            else if (r < 62) b = 8'hF0;
            else if (r < 70) b = 8'hE0;
            else if (r < 85) b = prev;
            else b = 8'($urandom_range(0, 255));
            prev = b;
            send(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) != 0));
            compare_all("rnd");
        end

        // async reset mid-frame with a pending letter
        kbd.key_ready = 1'b0;
        m_ready = 0;
        send(8'hF0, 1'b0, 1'b1);
        send(8'hE0, 1'b0, 1'b1);
        send(8'h5A, 1'b0, 1'b1);
        l = (m_held + 1) % 26;
        send(letters[l], 1'b0, 1'b1);
        chk("t7:pending_valid", int'(kbd.key_valid), 1);
        ps2_bits(frame_bits(8'h24, 1'b0, 1'b1), 4);
        rst = 1'b1;
        #1;
        chk("t7:rst_valid", int'(kbd.key_valid), 0);
        chk("t7:rst_code", int'(kbd.key_code), 0);
        chk("t7:rst_frame_err", int'(frame_err), 0);
        chk("t7:rst_overrun", int'(overrun), 0);
        m_ext = 0; m_brk = 0; m_held = -1; m_full = 0;
        cyc(5);
        rst = 1'b0;
        kbd.key_ready = 1'b1;
        m_ready = 1;
        cyc(5);
        send(8'h1C, 1'b0, 1'b1);
        compare_all("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

Keyboard front end for the Enigma datapath: receives PS/2 scan-code frames from a physical keyboard and converts letter make codes into 5-bit letter indices (A=0 … Z=25). It hands each keystroke to the rotor/plugboard pipeline over a valid/ready handshake. This is the input end of the path whose output end drives the lampboard. It also suppresses break codes, extended codes, non-letter keys and typematic repeats, so exactly one letter is issued per physical key press.

## Interface
- FILTER_LEN, 8, number of consecutive identical synchronized samples needed before the filtered ps2_clk changes level (≥2)
- TIMEOUT_CYCLES, 20000, number of clk cycles without a filtered ps2_clk falling edge, while mid-frame, after which the frame is aborted
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ps2_clk  input  1  PS/2 clock pin, asynchronous to clk
- ps2_data  input  1  PS/2 data pin, asynchronous to clk
- key_code  output  5  letter index 0–25; meaningful only while key_valid=1
- key_valid  output  1  a letter is held in the output register
- key_ready  input  1  consumer accepts; a transfer occurs when key_valid & key_ready are both 1 on a clk edge
- frame_err  output  1  one-cycle pulse on a parity error, a stop-bit error or a timeout
- overrun  output  1  one-cycle pulse when a decoded letter is dropped because the output register is full

## Operation
- **Input conditioning**
  - Both pins pass through a 2-FF synchronizer.
  - A FILTER_LEN-deep shift register on the synchronized ps2_clk drives the filtered clock: it goes 0 only when all samples are 0 and goes 1 only when all samples are 1.
  - Filtered clock resets to 1.
  - A falling edge of the filtered clock samples synchronized ps2_data.
- **Frame FSM**: states IDLE → DATA → PARITY → STOP → IDLE, advancing one step per falling edge.
  - IDLE: a sampled 0 is the start bit; go to DATA with bit count 0. A sampled 1 is ignored; stay in IDLE with no error.
  - DATA: shift the sampled bit into the byte, LSB first. After 8 bits, go to PARITY.
  - PARITY: store the bit. Odd parity is required: the eight data bits plus the parity bit must contain an odd number of ones.
  - STOP: the stop bit must be 1 and the parity must be good; otherwise pulse frame_err and discard the byte. Return to IDLE in either case.
  - Timeout: in any state other than IDLE, TIMEOUT_CYCLES with no falling edge → pulse frame_err and go to IDLE. The partial byte is discarded; decoder flags are unchanged.
- **Decoder** (acts once per good byte)
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte with ext=1 is consumed without output; clear ext and brk.
  - Any other byte with brk=1 (and ext=0) is consumed without output. If the byte is the held key's code, clear held. Clear brk.
  - Otherwise, a letter make code produces an output unless held is valid and equals that letter (typematic repeat). When it produces an output, set held to that letter.
  - Non-letter make codes are ignored and leave held unchanged.
- **Letter table** (set 2 make codes): A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
- **Output register** (single entry)
  - A new letter with key_valid=0 is loaded, and key_valid is set.
  - A new letter with key_valid=1 and key_ready=1 in the same cycle is also loaded; key_valid stays 1.
  - A new letter with key_valid=1 and key_ready=0: the letter is dropped, overrun pulses and held is still updated. key_code does not change.
  - A transfer with no new letter clears key_valid.
  - key_code is stable for as long as key_valid=1.

## Timing
- Reset values: key_code=0, key_valid=0, frame_err=0, overrun=0, FSM in IDLE, bit count 0, ext=brk=0, held invalid, timeout counter 0, synchronizers and filter all 1.
- An asynchronous rst assertion mid-frame aborts immediately. No pulses are produced and any pending key_valid is cleared.
- Pin-to-sample latency: 2 sync cycles + FILTER_LEN cycles from the ps2_clk fall.
- key_valid (or overrun, or frame_err) asserts on the clk edge after the cycle in which the stop-bit falling edge is detected. frame_err on a timeout asserts on the cycle after the counter reaches TIMEOUT_CYCLES.
- frame_err and overrun are exactly one cycle wide.
- Timeout counter clears on every falling edge and while in IDLE.
- Throughput: at most one letter per 11-bit frame. The output register never needs more than one entry, except when the consumer stalls.

## Test plan
- Reset, then frame 0x1C (parity 0, stop 1) with key_ready=1 → key_valid pulses for 1 cycle with key_code=0; no frame_err.
- Frames 0x1C, 0x1C, 0x1C, F0, 1C, 1C → exactly two letters, both key_code=0: the repeats are suppressed and the press after the break is issued.
- Frame 0x1C sent with parity bit 1 → frame_err pulses once, key_valid stays 0. Then frame 0x1A sent with stop bit 0 → frame_err again.
- E0 then 0x1C, and also 0x5A (Enter) → no output; a following 0x1A → key_code=25.
- key_ready=0, frames 0x32 then 0x21 → key_code=1 is held with key_valid=1, overrun pulses once. Then key_ready=1 → one transfer of value 1.
- Send 5 bits, then stall ps2_clk for TIMEOUT_CYCLES → frame_err pulses and the FSM returns to IDLE; the next full frame 0x23 → key_code=3. Separately, rst asserted mid-frame → all outputs 0 immediately.
